// File: rtl/goldschmidt_pkg.sv
// goldschmidt_pkg: state encoding, datapath select codes and word width shared
// by the Goldschmidt controller and datapath.
package goldschmidt_pkg;
   localparam int WIDTH = 16;
   localparam logic [1:0] ND_SEL_IA_D = 2'b00;
   localparam logic [1:0] ND_SEL_IA_N = 2'b01;
   localparam logic [1:0] ND_SEL_K_D  = 2'b10;
   localparam logic [1:0] ND_SEL_K_N  = 2'b11;
   localparam logic K_SEL_IA = 1'b1;
   localparam logic K_SEL_FB = 1'b0;
   typedef enum logic [2:0] {
      S_IDLE, S_INIT_D, S_INIT_N, S_ITER_D, S_ITER_N, S_DONE
   } state_t;
endpackage

// File: rtl/goldschmidt_ctrl.sv
// goldschmidt_ctrl: sequences the IA pass plus ITERS (K*D, K*N) refinement
// pairs and captures the final N product as the quotient.
module goldschmidt_ctrl
   import goldschmidt_pkg::*;
#(
   parameter int ITERS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] result,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             load_regN,
   output logic             load_regD,
   output logic [1:0]       sel_ND_mux,
   output logic             sel_K_mux,
   output logic [WIDTH-1:0] q
);
   // Index of the last refinement pair; cnt never exceeds it, so it cannot wrap.
   localparam logic [3:0] LAST = ITERS > 0 ? 4'(ITERS - 1) : 4'd0;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] q_d;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         q       <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q       <= q_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      load_regN  = 1'b0;
      load_regD  = 1'b0;
      sel_ND_mux = ND_SEL_IA_D;
      sel_K_mux  = K_SEL_FB;
      case (state_q)
         S_IDLE: begin
            state_d = start ? S_INIT_D : S_IDLE;
            cnt_d   = start ? 4'd0 : cnt_q;
         end
         S_INIT_D: begin
            state_d   = S_INIT_N;
            load_regD = 1'b1;
            sel_K_mux = K_SEL_IA;
         end
         S_INIT_N: begin
            state_d    = ITERS > 0 ? S_ITER_D : S_DONE;
            load_regN  = 1'b1;
            sel_ND_mux = ND_SEL_IA_N;
            sel_K_mux  = K_SEL_IA;
         end
         S_ITER_D: begin
            state_d    = S_ITER_N;
            load_regD  = 1'b1;
            sel_ND_mux = ND_SEL_K_D;
         end
         S_ITER_N: begin
            state_d    = cnt_q < LAST ? S_ITER_D : S_DONE;
            cnt_d      = cnt_q < LAST ? cnt_q + 4'd1 : cnt_q;
            load_regN  = 1'b1;
            sel_ND_mux = ND_SEL_K_N;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Only the final N-product state can step into DONE.
      q_d = state_d == S_DONE ? result : q;
   end
   assign ready = state_q == S_IDLE;
   assign busy  = state_q inside {S_INIT_D, S_INIT_N, S_ITER_D, S_ITER_N};
   assign done  = state_q == S_DONE;
endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// tb_goldschmidt_ctrl: runs ITERS=4 and ITERS=0 controllers side by side against
// a cycle-position model, plus hand-computed literal checks.
module tb_goldschmidt_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic [15:0] result = '0;
   wire [7:0] v4, v0;
   wire [15:0] q4, q0;
   int total = 0, bad = 0;
   bit chk_en = 1'b0;
   int pos [2] = '{0, 0};
   logic [15:0] qm [2] = '{16'h0, 16'h0};
   int dones;

   always #5 clk = ~clk;

   goldschmidt_ctrl #(.ITERS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .result(result),
      .ready(v4[7]), .busy(v4[6]), .done(v4[5]), .load_regN(v4[4]),
      .load_regD(v4[3]), .sel_ND_mux(v4[2:1]), .sel_K_mux(v4[0]), .q(q4));
   goldschmidt_ctrl #(.ITERS(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .result(result),
      .ready(v0[7]), .busy(v0[6]), .done(v0[5]), .load_regN(v0[4]),
      .load_regD(v0[3]), .sel_ND_mux(v0[2:1]), .sel_K_mux(v0[0]), .q(q0));

   function automatic int iters_of(int i);
      return i == 0 ? 4 : 0;
   endfunction

   // Outputs {ready,busy,done,load_regN,load_regD,sel_ND_mux,sel_K_mux} for a
   // given number of cycles since start was accepted (0 = idle).
   function automatic logic [7:0] exp_vec(int p, int it);
      if (p == 0) return 8'b1000_0000;
      if (p == 1) return 8'b0100_1001;
      if (p == 2) return 8'b0101_0011;
      if (p == 3 + 2 * it) return 8'b0010_0000;
      return (p % 2 == 1) ? 8'b0100_1100 : 8'b0101_0110;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            pos[i] = 0;
            qm[i] = '0;
         end else if (pos[i] == 0) begin
            pos[i] = start ? 1 : 0;
         end else begin
            if (pos[i] == 2 + 2 * iters_of(i)) qm[i] = result;
            pos[i] = (pos[i] == 3 + 2 * iters_of(i)) ? 0 : pos[i] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ctl4", {24'h0, v4}, {24'h0, exp_vec(pos[0], 4)});
         check("q4", {16'h0, q4}, {16'h0, qm[0]});
         check("ctl0", {24'h0, v0}, {24'h0, exp_vec(pos[1], 0)});
         check("q0", {16'h0, q0}, {16'h0, qm[1]});
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      tick();
      reset = 1'b0;
      chk_en = 1'b1;
      repeat (5) tick();
      check("idle_ready", {24'h0, v4}, 32'h80);
      check("idle_q", {16'h0, q4}, 32'h0);

      // ITERS=4 schedule with result = cycle index; start re-pulsed in cycles 3..8
      start = 1'b1;
      result = 16'd0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         start = (k >= 3 && k <= 8);
         result = 16'(k);
         if (k == 1) check("a_initd", {24'h0, v4}, 32'h49);
         if (k == 2) check("a_initn", {24'h0, v4}, 32'h53);
         if (k == 3) check("a_iterd", {24'h0, v4}, 32'h4C);
         if (k == 10) check("a_lastn", {24'h0, v4}, 32'h56);
         if (k == 11) check("a_done", {24'h0, v4}, 32'h20);
         if (k == 11) check("a_q", {16'h0, q4}, 32'h000A);
         if (k == 12) check("a_idle", {24'h0, v4}, 32'h80);
      end
      start = 1'b0;

      // ITERS=0: capture at the edge leaving INIT_N
      start = 1'b1;
      result = 16'h0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         start = 1'b0;
         result = (k == 2) ? 16'hBEEF : 16'h0;
         if (k == 3) check("b_done0", {24'h0, v0}, 32'h20);
         if (k == 3) check("b_q0", {16'h0, q0}, 32'hBEEF);
         if (k == 4) check("b_idle0", {24'h0, v0}, 32'h80);
      end

      // start held high: restart at the first IDLE cycle
      start = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         result = 16'h1234 + 16'(k);
         if (k == 12) check("c_idle", {24'h0, v4}, 32'h80);
         if (k == 13) check("c_restart", {24'h0, v4}, 32'h49);
      end
      start = 1'b0;
      repeat (12) tick();

      // reset mid-operation in cycle 6
      start = 1'b1;
      dones = 0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         start = 1'b0;
         reset = (k == 6);
         if (k == 7) check("d_idle", {24'h0, v4}, 32'h80);
         if (k == 7) check("d_q", {16'h0, q4}, 32'h0);
         if (k >= 7 && v4[5]) dones++;
      end
      check("d_nodone", 32'(dones), 32'd0);

      // reset and start together: reset wins
      reset = 1'b1;
      start = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      check("e_resetwins", {24'h0, v4}, 32'h80);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/goldschmidt_ctrl.md
# goldschmidt_ctrl

Sequencing controller for the 16-bit Goldschmidt division datapath. It accepts a start request, then drives the datapath's register-load and mux-select controls through the fixed schedule: the initial IA·D and IA·N products, followed by ITERS refinement pairs (K·D, K·N). On the final N product it captures the datapath `result` into a holding register and signals completion. It sits between the top-level divider wrapper (start/done handshake) and the `datapath` instance.

## Interface
- `ITERS`, default 4: number of refinement pairs after the initial IA pass; legal range 0..15.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a division; sampled only in IDLE.
- `ready` out 1: high only in IDLE.
- `busy` out 1: high in INIT_D, INIT_N, ITER_D and ITER_N.
- `done` out 1: one-cycle pulse in DONE.
- `load_regN` out 1: datapath N-register load enable.
- `load_regD` out 1: datapath D-register load enable.
- `sel_ND_mux` out 2: datapath operand select.
- `sel_K_mux` out 1: 1 selects IA as multiplier; 0 selects the fed-back K.
- `result` in 16: datapath product output (combinational in datapath).
- `q` out 16: captured quotient; holds its value until the next capture or reset.

## Operation
- States: IDLE, INIT_D, INIT_N, ITER_D, ITER_N, DONE.
- Transitions:
  - IDLE→INIT_D on `start`.
  - INIT_D→INIT_N.
  - INIT_N→ITER_D if ITERS>0, else →DONE.
  - ITER_D→ITER_N.
  - ITER_N→ITER_D if cnt<ITERS-1, else →DONE.
  - DONE→IDLE.
- Moore control outputs, decoded from state only:
  - IDLE/DONE: load_regN=0, load_regD=0, sel_ND_mux=00, sel_K_mux=0.
  - INIT_D: load_regD=1, sel_ND_mux=00, sel_K_mux=1.
  - INIT_N: load_regN=1, sel_ND_mux=01, sel_K_mux=1.
  - ITER_D: load_regD=1, sel_ND_mux=10, sel_K_mux=0.
  - ITER_N: load_regN=1, sel_ND_mux=11, sel_K_mux=0.
- load_regN and load_regD are never both 1 in the same cycle.
- Iteration counter `cnt`, width 4:
  - cleared on entry to INIT_D;
  - increments on each ITER_N→ITER_D transition;
  - saturates, never wraps (ITERS ≤ 15).
- Capture: `q <= result` on the clock edge that leaves the final N-product state (ITER_N when ITERS>0; INIT_N when ITERS=0). `q` is unchanged at all other edges.
- `start` outside IDLE is ignored and not queued. `start` held high through DONE starts a new operation at the first IDLE cycle.
- `result` is used only at the capture edge; its value is unconstrained at all other times.

## Timing
- `start` sampled high at edge 0 gives: INIT_D in cycle 1, INIT_N in cycle 2, ITER states in cycles 3..2+2·ITERS, DONE in cycle 3+2·ITERS.
- ITERS=4: DONE in cycle 11, back in IDLE in cycle 12.
- `q` is valid in the DONE cycle, coincident with `done`.
- Minimum start-to-start spacing: 4+2·ITERS cycles.
- Reset values: state=IDLE, cnt=0, q=16'h0000, ready=1, busy=0, done=0, all load and select outputs 0.
- Reset mid-operation: IDLE at the next edge, no capture, `q` cleared. The datapath registers are left as they are.
- Reset and start both high: reset wins.

## Structure
- Shared package `goldschmidt_pkg`:
  - state enum;
  - ND_SEL_IA_D=2'b00, ND_SEL_IA_N=2'b01, ND_SEL_K_D=2'b10, ND_SEL_K_N=2'b11;
  - K_SEL_IA=1'b1, K_SEL_FB=1'b0;
  - WIDTH=16.
- The `datapath` module imports the same select constants.
- Flat FSM, no sub-module. Integration bench instantiates `goldschmidt_ctrl` plus `datapath` in a wrapper `goldschmidt_div`.

## Test plan
- Reset, then idle 5 cycles → ready=1, busy=0, done=0, all control outputs 0, q=0000.
- ITERS=4, start pulse at edge 0, bench drives result=cycle index → control sequence (load_regD, sel_ND_mux, sel_K_mux) / (load_regN, ...) matches the schedule for cycles 1..10; done only in cycle 11; q=000A.
- ITERS=0, result=16'hBEEF in cycle 2 → done in cycle 3, q=BEEF, no ITER states visited.
- start re-asserted during cycles 3..8 → no effect on sequence. Start held high through DONE → new INIT_D in cycle 13.
- reset asserted in cycle 6 (ITERS=4) → IDLE at cycle 7, q=0000, all loads 0, no done pulse.
- Full wrapper with N=0x4B3C, D=0x7E50 (Q1.15 fixed point, as used by the datapath) → q within 2 LSB of the floating-point reference quotient, done at cycle 11.
